// File: rtl/psola_playback.sv
// -----------------------------------------------------------------------------
// psola_playback
//
// Drains the PSOLA overlap-add output buffer at the audio sample rate. After
// the overlap-add stage pulses psola_done, one buffer word is fetched for each
// sample_tick. Each word is a 32-bit signed Q.FRAC_BITS value; it is converted
// to a saturated signed OUT_WIDTH sample. Every location is zeroed right after
// it is read, so the next PSOLA pass accumulates into a clean buffer.
//
// Ports:
//   clk_in        system clock (single domain)
//   rst_in        synchronous active-low reset
//   psola_done    one-cycle pulse: buffer complete; window_len sampled here
//   window_len    number of valid buffer words
//   sample_tick   one-cycle audio-rate strobe
//   read_addr     registered buffer read address
//   read_data     buffer word for the read_addr presented two cycles earlier
//   clear_addr    buffer write address used for zeroing
//   clear_we      buffer write enable (write data is always zero)
//   sample_out    registered signed output sample
//   sample_valid  one-cycle pulse when sample_out updates
//   busy          high from the psola_done latch until the drain ends
//   frame_done    one-cycle pulse when the last word has been emitted
//   underrun      one-cycle pulse: sample_tick arrived while idle
//   overrun       one-cycle pulse: sample_tick arrived during a fetch
// -----------------------------------------------------------------------------
module psola_playback #(
    parameter int WINDOW_SIZE = 2048,
    parameter int FRAC_BITS   = 10,
    parameter int OUT_WIDTH   = 16
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        psola_done,
    input  logic [11:0]                 window_len,
    input  logic                        sample_tick,
    output logic [$clog2(WINDOW_SIZE):0] read_addr,
    input  logic [31:0]                 read_data,
    output logic [$clog2(WINDOW_SIZE):0] clear_addr,
    output logic                        clear_we,
    output logic signed [OUT_WIDTH-1:0] sample_out,
    output logic                        sample_valid,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        underrun,
    output logic                        overrun
);

    localparam int AW = $clog2(WINDOW_SIZE) + 1;

    localparam logic [AW-1:0]      LEN_MAX = AW'(WINDOW_SIZE);
    localparam logic signed [31:0] SAT_MAX = 32'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [31:0] SAT_MIN = -SAT_MAX - 32'sd1;

    // Drop the fraction (arithmetic shift floors toward -inf), then clamp.
    function automatic logic signed [OUT_WIDTH-1:0] sat_sample(
        input logic signed [31:0] word
    );
        logic signed [31:0] shifted;
        shifted = word >>> FRAC_BITS;
        if (shifted > SAT_MAX) begin
            return SAT_MAX[OUT_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            return SAT_MIN[OUT_WIDTH-1:0];
        end else begin
            return shifted[OUT_WIDTH-1:0];
        end
    endfunction

    // FETCH1 is cycle T+1 (address in flight); FETCH2 is cycle T+2 (data valid).
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PLAY   = 2'd1,
        S_FETCH1 = 2'd2,
        S_FETCH2 = 2'd3
    } state_t;

    state_t                        r_state;
    logic [AW-1:0]                 r_idx;
    logic [AW-1:0]                 r_len;
    logic [AW-1:0]                 r_read_addr;
    logic [AW-1:0]                 r_clear_addr;
    logic                          r_clear_we;
    logic signed [OUT_WIDTH-1:0]   r_sample;
    logic                          r_vld;
    logic                          r_busy;
    logic                          r_frame_done;
    logic                          r_underrun;
    logic                          r_overrun;

    state_t                        w_state_nxt;
    logic [AW-1:0]                 w_idx_nxt;
    logic [AW-1:0]                 w_len_nxt;
    logic [AW-1:0]                 w_read_addr_nxt;
    logic [AW-1:0]                 w_clear_addr_nxt;
    logic                          w_clear_we_nxt;
    logic signed [OUT_WIDTH-1:0]   w_sample_nxt;
    logic                          w_vld_nxt;
    logic                          w_busy_nxt;
    logic                          w_frame_done_nxt;
    logic                          w_underrun_nxt;
    logic                          w_overrun_nxt;
    logic [AW-1:0]                 w_idx_inc;

    assign w_idx_inc = r_idx + AW'(1);

    // ---- Stage: next-state decode ----
    always_comb begin
        w_state_nxt      = r_state;
        w_idx_nxt        = r_idx;
        w_len_nxt        = r_len;
        w_read_addr_nxt  = r_read_addr;
        w_clear_addr_nxt = r_clear_addr;
        w_clear_we_nxt   = 1'b0;
        w_sample_nxt     = r_sample;
        w_vld_nxt        = 1'b0;
        w_busy_nxt       = r_busy;
        w_frame_done_nxt = 1'b0;
        w_underrun_nxt   = 1'b0;
        w_overrun_nxt    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (psola_done) begin
                    if (window_len != 12'd0) begin
                        if (32'(window_len) > 32'(WINDOW_SIZE)) begin
                            w_len_nxt = LEN_MAX;
                        end else begin
                            w_len_nxt = AW'(window_len);
                        end
                        w_idx_nxt       = '0;
                        w_read_addr_nxt = '0;
                        w_busy_nxt      = 1'b1;
                        w_state_nxt     = S_PLAY;
                    end else begin
                        w_frame_done_nxt = 1'b1;
                    end
                end
                // A tick here emits silence even if the latch happens in the
                // same cycle; the first real fetch waits for the next tick.
                if (sample_tick) begin
                    w_sample_nxt   = '0;
                    w_vld_nxt      = 1'b1;
                    w_underrun_nxt = 1'b1;
                end
            end

            S_PLAY: begin
                if (sample_tick) begin
                    w_state_nxt = S_FETCH1;
                end
            end

            S_FETCH1: begin
                if (sample_tick) begin
                    w_overrun_nxt = 1'b1;
                end
                // Registered so the zeroing write lands in the data-valid
                // cycle, after the word has already left the buffer.
                w_clear_we_nxt   = 1'b1;
                w_clear_addr_nxt = r_idx;
                w_state_nxt      = S_FETCH2;
            end

            S_FETCH2: begin
                if (sample_tick) begin
                    w_overrun_nxt = 1'b1;
                end
                w_sample_nxt    = sat_sample($signed(read_data));
                w_vld_nxt       = 1'b1;
                w_idx_nxt       = w_idx_inc;
                w_read_addr_nxt = w_idx_inc;
                if (w_idx_inc == r_len) begin
                    w_busy_nxt       = 1'b0;
                    w_frame_done_nxt = 1'b1;
                    w_state_nxt      = S_IDLE;
                end else begin
                    w_state_nxt = S_PLAY;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ---- Stage: state and output registers ----
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_len        <= '0;
            r_read_addr  <= '0;
            r_clear_addr <= '0;
            r_clear_we   <= 1'b0;
            r_sample     <= '0;
            r_vld        <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_len        <= w_len_nxt;
            r_read_addr  <= w_read_addr_nxt;
            r_clear_addr <= w_clear_addr_nxt;
            r_clear_we   <= w_clear_we_nxt;
            r_sample     <= w_sample_nxt;
            r_vld        <= w_vld_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_underrun   <= w_underrun_nxt;
            r_overrun    <= w_overrun_nxt;
        end
    end

    assign read_addr    = r_read_addr;
    assign clear_addr   = r_clear_addr;
    assign clear_we     = r_clear_we;
    assign sample_out   = r_sample;
    assign sample_valid = r_vld;
    assign busy         = r_busy;
    assign frame_done   = r_frame_done;
    assign underrun     = r_underrun;
    assign overrun      = r_overrun;

endmodule
